sc_decode_et: RTL and testbench

SC_DECODE_ET -- requirements
Module: sc_decode_et

---
 rtl/sc_pkg.sv | 19 +
 rtl/sc_ones_ctr.sv | 36 +++
 rtl/sc_decode_et.sv | 111 +++++++++++
 tb/tb_sc_decode_et.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and width helpers for the stochastic-computing decoder.
// Pure declarations: no latency, no flow control.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sc_state_t;

  function automatic int sc_sw(input int width, input int num_inputs);
    return width * num_inputs;
  endfunction

  function automatic int sc_maxlen(input int sw);
    return 1 << sw;
  endfunction

endpackage

// File: rtl/sc_ones_ctr.sv
// Per-stream ones accumulator: sync clear beats enable, adds the input bit when enabled.
// One-cycle update latency; no flow control.
module sc_ones_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sc_decode_et.sv
// Counts ones and length of NUM_OUTPUTS stochastic streams until gen_done or MAXLEN.
// result_valid is registered (one cycle after end); result held until result_ready or start.
module sc_decode_et
  import sc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_OUTPUTS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        bit_valid,
  input  logic [NUM_OUTPUTS-1:0]      Zs,
  input  logic                        gen_done,
  input  logic                        result_ready,
  output logic                        result_valid,
  output logic [WIDTH*NUM_INPUTS:0]   ones [NUM_OUTPUTS-1:0],
  output logic [WIDTH*NUM_INPUTS:0]   len,
  output logic                        ovf
);

  localparam int SW = sc_sw(WIDTH, NUM_INPUTS);
  localparam logic [SW:0] MAXLEN = (SW+1)'(sc_maxlen(SW));

  sc_state_t   state_q, state_d;
  logic [SW:0] len_q, len_d;
  logic        ovf_q, ovf_d;
  logic        rv_q, rv_d;
  logic        cnt_clr;
  logic        cnt_en;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // start outranks gen_done; the gen_done-cycle bit belongs to the next period
        if (start) begin
          cnt_clr = 1'b1;
          len_d   = '0;
          ovf_d   = 1'b0;
        end else if (gen_done) begin
          ovf_d   = 1'b0;
          state_d = HOLD;
        end else if (bit_valid) begin
          if (len_q == MAXLEN) begin
            ovf_d   = 1'b1;
            state_d = HOLD;
          end else begin
            len_d  = len_q + (SW+1)'(1);
            cnt_en = 1'b1;
          end
        end
      end
      HOLD: begin
        if (start) begin
          cnt_clr = 1'b1;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rv_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
    end
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_ctr
    sc_ones_ctr #(.W(SW+1)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .inc   (Zs[k]),
      .cnt   (ones[k])
    );
  end

  assign result_valid = rv_q;
  assign len          = len_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_sc_decode_et.sv
// Directed bench for sc_decode_et (WIDTH=4, NUM_INPUTS=2, NUM_OUTPUTS=2, MAXLEN=256).
// A conversion-level model is compared every cycle; literal checks pin the model.
module tb_sc_decode_et;

  localparam int MAXLEN = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic [1:0] Zs = 2'b00;
  logic       gen_done = 1'b0;
  logic       result_ready = 1'b0;
  logic       result_valid;
  logic [8:0] ones [1:0];
  logic [8:0] len;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_decode_et #(.WIDTH(4), .NUM_INPUTS(2), .NUM_OUTPUTS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bit_valid    (bit_valid),
    .Zs           (Zs),
    .gen_done     (gen_done),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .ones         (ones),
    .len          (len),
    .ovf          (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Conversion-level model: 0 = quiet, 1 = collecting, 2 = presenting result
  int m_phase;
  int m_len;
  int m_ones [2];
  int m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_len = 0; m_ones[0] = 0; m_ones[1] = 0; m_ovf = 0;
    end else if (start && m_phase != 0 || start && m_phase == 0) begin
      m_phase = 1; m_len = 0; m_ones[0] = 0; m_ones[1] = 0; m_ovf = 0;
    end else if (m_phase == 1) begin
      if (gen_done) begin
        m_phase = 2; m_ovf = 0;
      end else if (bit_valid) begin
        if (m_len >= MAXLEN) begin
          m_phase = 2; m_ovf = 1;
        end else begin
          m_len++;
          for (int k = 0; k < 2; k++) m_ones[k] += int'(Zs[k]);
        end
      end
    end else if (m_phase == 2 && result_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    chk("model_rv",    32'(result_valid), 32'(m_phase == 2));
    chk("model_len",   32'(len),          32'(m_len));
    chk("model_ovf",   32'(ovf),          32'(m_ovf));
    chk("model_ones0", 32'(ones[0]),      32'(m_ones[0]));
    chk("model_ones1", 32'(ones[1]),      32'(m_ones[1]));
  end

  task automatic step(input logic s, input logic bv, input logic [1:0] z,
                      input logic gd, input logic rr);
    start = s; bit_valid = bv; Zs = z; gen_done = gd; result_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string nm, input int rv, input int l,
                         input int o1, input int o0, input int ov);
    chk({nm, "_rv"},   32'(result_valid), 32'(rv));
    chk({nm, "_len"},  32'(len),          32'(l));
    chk({nm, "_ones1"},32'(ones[1]),      32'(o1));
    chk({nm, "_ones0"},32'(ones[0]),      32'(o0));
    chk({nm, "_ovf"},  32'(ovf),          32'(ov));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_res("reset", 0, 0, 0, 0, 0);

    // Full-length stream, gen_done bit must not be counted
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 256; i++) step(0, 1, {i < 192, i < 64}, 0, 0);
    chk("full_pre_rv", 32'(result_valid), 32'd0);
    step(0, 1, 2'b11, 1, 0);
    chk_res("full", 1, 256, 192, 64, 0);
    step(0, 0, 2'b00, 0, 1);
    chk_res("full_ack", 0, 256, 192, 64, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b11, 1, 0);
    chk_res("idle_ignore", 0, 256, 192, 64, 0);

    // Early termination
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 2'b11, 0, 0);
    step(0, 0, 2'b00, 1, 0);
    chk_res("early", 1, 16, 16, 16, 0);
    step(0, 0, 2'b00, 0, 1);

    // Alternating bit_valid
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 40; i++) step(0, (i % 2) == 0, 2'b01, 0, 0);
    step(0, 0, 2'b00, 1, 0);
    chk_res("alt", 1, 20, 0, 20, 0);
    step(0, 0, 2'b00, 0, 1);

    // MAXLEN guard, then held under random noise without result_ready
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 257; i++) step(0, 1, 2'b01, 0, 0);
    chk_res("ovf", 1, 256, 0, 256, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1'($urandom), 2'($urandom), 1'($urandom), 0);
      chk_res("ovf_hold", 1, 256, 0, 256, 1);
    end
    step(0, 0, 2'b00, 0, 1);

    // Restart mid-RUN, then start+ready from HOLD
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 2'b11, 0, 0);
    step(1, 1, 2'b11, 1, 0);
    chk_res("restart", 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b10, 0, 0);
    step(0, 0, 2'b00, 1, 0);
    chk_res("restart_done", 1, 8, 8, 0, 0);
    step(1, 0, 2'b00, 0, 1);
    chk_res("hold_start", 0, 0, 0, 0, 0);

    // Async reset mid-RUN
    for (int i = 0; i < 100; i++) step(0, 1, 2'b11, 0, 0);
    chk("pre_rst_len", 32'(len), 32'd100);
    #2 rst_n = 1'b0;
    #1 chk_res("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 1, 2'b11, 1, 0);
    chk_res("post_rst_idle", 0, 0, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 0, 0);
    step(0, 0, 2'b00, 1, 0);
    chk_res("post_rst_conv", 1, 5, 0, 5, 0);
    step(0, 0, 2'b00, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
